// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared constants for the pushbutton conditioner
package button_conditioner_pkg;

  // Button roles as seen by the ALU top-level load strobes
  localparam int BTN_DATO_A = 0;
  localparam int BTN_DATO_B = 1;
  localparam int BTN_OPCODE = 2;
  localparam int BTN_UPDATE = 3;

  localparam int N_BUTTONS_DEFAULT   = 4;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-flop synchroniser, counter debouncer, rising-edge one-shot
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_boton,
  output logic o_level,
  output logic o_pulse
);

  localparam int NB_COUNT = $clog2(DEBOUNCE_CYCLES);
  localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);

  logic                q1;
  logic                q2;
  logic [NB_COUNT-1:0] cnt;

  // Counter only runs while q2 differs from o_level, so it tops out at CNT_LAST
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q1      <= 1'b0;
      q2      <= 1'b0;
      cnt     <= '0;
      o_level <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      q1      <= i_boton;
      q2      <= q1;
      o_pulse <= 1'b0;
      if (q2 == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_level <= q2;
        o_pulse <= q2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - independent debounced level and press strobe per button
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BUTTONS       = N_BUTTONS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_boton,
  output logic [N_BUTTONS-1:0] o_level,
  output logic [N_BUTTONS-1:0] o_pulse
);

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_boton(i_boton[g]),
      .o_level(o_level[g]),
      .o_pulse(o_pulse[g])
    );
  end

endmodule
